// File: rtl/spike_event_fifo_pkg.sv
// Shared sizing constants and the event word type for the spike event FIFO.
package spike_event_fifo_pkg;

    localparam int unsigned FIFO_WIDTH      = 12;
    localparam int unsigned FIFO_DEPTH      = 128;
    localparam int          FIFO_LEVEL_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int          FIFO_AF_MARGIN  = 4;

    typedef logic [FIFO_WIDTH-1:0] spike_event_t;

endpackage

// File: rtl/spike_event_fifo_ptr.sv
// Wrapping 0..DEPTH-1 pointer with increment enable; wraps explicitly so any DEPTH works.
module spike_fifo_ptr
    import spike_event_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/spike_event_fifo.sv
// Single-clock first-word-fall-through spike event FIFO with level, almost-full and optional drop-on-full.
// Build option SPIKE_FIFO_STATS_EN adds the drop_cnt and peak_level statistics ports.
module spike_event_fifo
    import spike_event_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = FIFO_WIDTH,
    parameter int unsigned DEPTH        = FIFO_DEPTH,
    parameter int unsigned AF_THRESH    = DEPTH - FIFO_AF_MARGIN,
    parameter bit          DROP_ON_FULL = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full
`ifdef SPIKE_FIFO_STATS_EN
    ,
    output logic [15:0]                  drop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   peak_level
`endif
);

    localparam int unsigned LEVEL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level_d;
    logic [LEVEL_W-1:0] level_q;
    logic               empty_d;
    logic               empty_q;
    logic               full_d;
    logic               full_q;
    logic               af_d;
    logic               af_q;
    logic               push_c;
    logic               pop_c;

    // Handshakes use only registered flags, so no ready/valid passes straight through.
    always_comb begin
        wr_ready = DROP_ON_FULL ? 1'b1 : ~full_q;
        rd_valid = ~empty_q;
        push_c   = wr_valid & wr_ready & ~full_q;
        pop_c    = rd_valid & rd_ready;
    end

    always_comb begin
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LEVEL_W'(1);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LEVEL_W'(DEPTH));
        af_d    = (level_d >= LEVEL_W'(AF_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
        end
    end

    // Storage is deliberately not reset; rd_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    spike_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_c),
        .ptr (wr_ptr)
    );

    spike_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_c),
        .ptr (rd_ptr)
    );

    assign rd_data     = mem_q[rd_ptr];
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;

`ifdef SPIKE_FIFO_STATS_EN
    logic [15:0]        drop_cnt_d;
    logic [15:0]        drop_cnt_q;
    logic [LEVEL_W-1:0] peak_level_d;
    logic [LEVEL_W-1:0] peak_level_q;

    // A write offered while full is only a drop in drop-on-full builds.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (DROP_ON_FULL && wr_valid && full_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        peak_level_d = (level_d > peak_level_q) ? level_d : peak_level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q   <= '0;
            peak_level_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            peak_level_q <= peak_level_d;
        end
    end

    assign drop_cnt   = drop_cnt_q;
    assign peak_level = peak_level_q;
`endif

endmodule

// File: tb/tb_spike_event_fifo.sv
// Scoreboard bench: a backpressure FIFO (DEPTH 128) and a drop-on-full FIFO (DEPTH 6) against queue models.
module tb_spike_event_fifo;

    localparam int W  = 12;
    localparam int DA = 128;
    localparam int DB = 6;
    localparam int LA = $clog2(DA + 1);
    localparam int LB = $clog2(DB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst = 1'b1, a_wr_valid = 1'b0, a_rd_ready = 1'b0;
    logic [W-1:0]  a_wr_data = '0;
    logic          a_wr_ready, a_rd_valid, a_empty, a_full, a_af;
    logic [W-1:0]  a_rd_data;
    logic [LA-1:0] a_level;

    logic          b_rst = 1'b1, b_wr_valid = 1'b0, b_rd_ready = 1'b0;
    logic [W-1:0]  b_wr_data = '0;
    logic          b_wr_ready, b_rd_valid, b_empty, b_full, b_af;
    logic [W-1:0]  b_rd_data;
    logic [LB-1:0] b_level;

`ifdef SPIKE_FIFO_STATS_EN
    logic [15:0]   a_drop_cnt, b_drop_cnt;
    logic [LA-1:0] a_peak;
    logic [LB-1:0] b_peak;
`endif

    spike_event_fifo u_a (
        .clk(clk), .rst(a_rst), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data), .level(a_level),
        .empty(a_empty), .full(a_full), .almost_full(a_af)
`ifdef SPIKE_FIFO_STATS_EN
        , .drop_cnt(a_drop_cnt), .peak_level(a_peak)
`endif
    );

    spike_event_fifo #(.WIDTH(W), .DEPTH(DB), .DROP_ON_FULL(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .level(b_level),
        .empty(b_empty), .full(b_full), .almost_full(b_af)
`ifdef SPIKE_FIFO_STATS_EN
        , .drop_cnt(b_drop_cnt), .peak_level(b_peak)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: occupancy, expected contents, drops and high-water mark.
    int lvl_a = 0, drops_a = 0, peak_a = 0;
    int lvl_b = 0, drops_b = 0, peak_b = 0;
    int exp_a[$];
    int exp_b[$];

    function automatic void chk(string name, logic [31:0] act, int req);
        checks++;
        if (act !== 32'(req)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: compares status against the model and the head entry against the scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_level", 32'(a_level), lvl_a);
            chk("a_empty", 32'(a_empty), int'(lvl_a == 0));
            chk("a_full", 32'(a_full), int'(lvl_a == DA));
            chk("a_almost_full", 32'(a_af), int'(lvl_a >= DA - 4));
            chk("a_wr_ready", 32'(a_wr_ready), int'(lvl_a != DA));
            chk("a_rd_valid", 32'(a_rd_valid), int'(lvl_a != 0));
            if (lvl_a > 0) begin
                chk("a_rd_data", 32'(a_rd_data), exp_a[0]);
                if (a_rd_ready && !a_rst) void'(exp_a.pop_front());
            end
            chk("b_level", 32'(b_level), lvl_b);
            chk("b_empty", 32'(b_empty), int'(lvl_b == 0));
            chk("b_full", 32'(b_full), int'(lvl_b == DB));
            chk("b_almost_full", 32'(b_af), int'(lvl_b >= DB - 4));
            chk("b_wr_ready", 32'(b_wr_ready), 1);
            chk("b_rd_valid", 32'(b_rd_valid), int'(lvl_b != 0));
            if (lvl_b > 0) begin
                chk("b_rd_data", 32'(b_rd_data), exp_b[0]);
                if (b_rd_ready && !b_rst) void'(exp_b.pop_front());
            end
`ifdef SPIKE_FIFO_STATS_EN
            chk("a_drop_cnt", 32'(a_drop_cnt), drops_a);
            chk("a_peak_level", 32'(a_peak), peak_a);
            chk("b_drop_cnt", 32'(b_drop_cnt), drops_b);
            chk("b_peak_level", 32'(b_peak), peak_b);
`endif
        end
    end

    // One cycle of stimulus on FIFO A; accepted writes go to the scoreboard immediately.
    task automatic step_a(input bit rst, input bit wv, input int wd, input bit rr);
        bit push, pop;
        a_rst = rst; a_wr_valid = wv; a_wr_data = W'(wd); a_rd_ready = rr;
        push = !rst && wv && (lvl_a < DA);
        pop  = !rst && rr && (lvl_a > 0);
        if (push) exp_a.push_back(wd & 'hFFF);
        @(posedge clk); #1;
        if (rst) begin
            lvl_a = 0; drops_a = 0; peak_a = 0; exp_a.delete();
        end else begin
            lvl_a = lvl_a + int'(push) - int'(pop);
            if (lvl_a > peak_a) peak_a = lvl_a;
        end
    endtask

    task automatic step_b(input bit rst, input bit wv, input int wd, input bit rr);
        bit push, pop;
        b_rst = rst; b_wr_valid = wv; b_wr_data = W'(wd); b_rd_ready = rr;
        push = !rst && wv && (lvl_b < DB);
        pop  = !rst && rr && (lvl_b > 0);
        if (push) exp_b.push_back(wd & 'hFFF);
        @(posedge clk); #1;
        if (rst) begin
            lvl_b = 0; drops_b = 0; peak_b = 0; exp_b.delete();
        end else begin
            if (wv && lvl_b == DB && drops_b < 65535) drops_b++;
            lvl_b = lvl_b + int'(push) - int'(pop);
            if (lvl_b > peak_b) peak_b = lvl_b;
        end
    endtask

    task automatic rand_a(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++)
            step_a(1'b0, $urandom_range(0, 99) < pw, int'($urandom_range(0, 4095)),
                   $urandom_range(0, 99) < pr);
    endtask

    task automatic rand_b(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++)
            step_b(1'b0, $urandom_range(0, 99) < pw, int'($urandom_range(0, 4095)),
                   $urandom_range(0, 99) < pr);
    endtask

    task automatic run_a();
        repeat (2) step_a(1'b1, 1'b0, 0, 1'b0);
        chk_en = 1'b1;
        repeat (3) step_a(1'b0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 128; i++) step_a(1'b0, 1'b1, i, 1'b0);
        repeat (2) step_a(1'b0, 1'b1, 'h555, 1'b0);
        step_a(1'b0, 1'b1, 'h3AA, 1'b1);
        repeat (127) step_a(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, int'($urandom_range(0, 4095)), 1'b0);
        for (int i = 0; i < 200; i++) step_a(1'b0, 1'b1, int'($urandom_range(0, 4095)), 1'b1);
        repeat (5) step_a(1'b0, 1'b0, 0, 1'b1);
        rand_a(400, 80, 40);
        rand_a(400, 40, 80);
        repeat (130) step_a(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 40; i++) step_a(1'b0, 1'b1, 'h100 + i, 1'b0);
        step_a(1'b1, 1'b1, 'hBAD, 1'b1);
        step_a(1'b0, 1'b1, 'h7E5, 1'b0);
        step_a(1'b0, 1'b0, 0, 1'b1);
        rand_a(300, 60, 60);
        step_a(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic run_b();
        repeat (2) step_b(1'b1, 1'b0, 0, 1'b0);
        repeat (3) step_b(1'b0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 6; i++) step_b(1'b0, 1'b1, 'h010 + i, 1'b0);
        for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1, 'hF00 + i, 1'b0);
        step_b(1'b0, 1'b1, 'hABC, 1'b1);
        repeat (5) step_b(1'b0, 1'b0, 0, 1'b1);
        rand_b(300, 85, 30);
        rand_b(300, 50, 50);
        step_b(1'b1, 1'b0, 0, 1'b0);
        rand_b(200, 70, 45);
        step_b(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        @(posedge clk); #1;
        fork
            run_a();
            run_b();
        join
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_event_fifo.md
# spike_event_fifo

Parametrised single-clock event FIFO carrying spike/pixel events between the AXI-side input stage and the neuron core. It has valid/ready handshakes on both sides, first-word-fall-through reads, an occupancy level output and a programmable almost-full flag. It also has a build-time choice between backpressure and drop-on-full. It is the next generation of the fixed 12-bit × N/2 event buffer: width, depth, threshold and full-policy are all parameters.

## Interface
- `WIDTH`, default `FIFO_WIDTH` (12): event word width in bits.
- `DEPTH`, default `FIFO_DEPTH` (128): number of entries; any value ≥ 2, not restricted to powers of two.
- `AF_THRESH`, default `DEPTH-4`: `almost_full` asserts when `level >= AF_THRESH`; legal range 1..`DEPTH`.
- `DROP_ON_FULL`, default 0:
  - 0: backpressure when full.
  - 1: `wr_ready` is held at 1 and writes arriving while full are discarded.
- `clk` in 1: the single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: producer has an event.
- `wr_ready` out 1: FIFO accepts the event.
- `wr_data` in `WIDTH`: event word.
- `rd_valid` out 1: head entry is available.
- `rd_ready` in 1: consumer takes the head entry.
- `rd_data` out `WIDTH`: head entry.
- `level` out `$clog2(DEPTH+1)`: current occupancy.
- `empty` out 1, `full` out 1, `almost_full` out 1: status flags.
- `drop_cnt` out 16: saturating count of discarded writes. Present only with `SPIKE_FIFO_STATS_EN`.
- `peak_level` out `$clog2(DEPTH+1)`: high-water mark. Present only with `SPIKE_FIFO_STATS_EN`.

## Operation
- Write handshake: `push = wr_valid & wr_ready & !full`.
- Read handshake: `pop = rd_valid & rd_ready`.
- Write data lands at `wr_ptr`. The head entry is `mem[rd_ptr]` and is driven combinationally onto `rd_data`.
- `rd_valid = !empty`.
- `wr_ready = DROP_ON_FULL ? 1 : !full`.
- Pointers run 0..`DEPTH-1` and wrap to 0 explicitly after `DEPTH-1`. They do not rely on power-of-two overflow.
- `level` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Flags come from the registered level: `empty = (level==0)`, `full = (level==DEPTH)`.
- Full with push and pop in the same cycle: the push is NOT accepted, because full is evaluated on pre-cycle state.
  - With `DROP_ON_FULL=1` that write counts as a drop.
  - With `DROP_ON_FULL=0`, `wr_ready` was already low, so no handshake occurs.
- Empty with push and pop in the same cycle: no pop, because `rd_valid=0`; the push is accepted.
- Drop (`DROP_ON_FULL=1`, `wr_valid & full`): memory, pointers and level are untouched. `drop_cnt` increments and saturates at 0xFFFF.
- Reset values: pointers 0, `level` 0, `empty` 1, `full` 0, `almost_full` 0, `rd_valid` 0, `drop_cnt` 0, `peak_level` 0.
- Memory contents are not reset, so `rd_data` is don't-care while `empty`.
- Reset mid-operation flushes all entries. The next cycle behaves exactly as after power-up.

## Timing
- Write-to-read latency is 1 cycle: an event pushed at edge k has `rd_valid=1` with that data after edge k.
- `level` and all flags update on the same edge as the handshake.
- Sustained throughput is 1 push and 1 pop per cycle whenever the FIFO is neither empty nor full.
- `rd_data` is stable while `rd_valid & !rd_ready`.
- There are no combinational paths from `rd_ready` to `wr_ready` or from `wr_valid` to `rd_valid`.

## Configuration
- Macro: `SPIKE_FIFO_STATS_EN`.
- Defined: the `drop_cnt` and `peak_level` ports and their logic exist.
  - `peak_level <= max(peak_level, next level)` each cycle.
  - Both values clear only on `rst`.
- Undefined: neither port nor any counter logic exists. FIFO behaviour is otherwise identical, including silent drops when `DROP_ON_FULL=1`.

## Structure
- `pa_SnnAccelerator` gains:
  - `typedef logic [FIFO_WIDTH-1:0] spike_event_t`
  - `localparam int FIFO_LEVEL_BITS = $clog2(FIFO_DEPTH+1)`
  - `localparam int FIFO_AF_MARGIN = 4`
- One sub-module, `spike_fifo_ptr`: a wrapping 0..`DEPTH-1` pointer with an increment enable. It is instantiated twice, once for the write pointer and once for the read pointer.

## Test plan
- Reset then idle: `empty=1`, `rd_valid=0`, `level=0`, `wr_ready=1`.
- Push 0x001..0x080 with `rd_ready=0` (`DEPTH=128`):
  - `almost_full` rises when `level` reaches 124.
  - `full=1` and `wr_ready=0` after the 128th push.
  - Reads then return 0x001..0x080 in order.
- Simultaneous push and pop at `level=5` for 200 cycles: `level` stays 5, data order is preserved, and both pointers wrap past 127.
- `DEPTH=6`, `DROP_ON_FULL=1`, stats on:
  - Fill to 6, then 3 extra writes: `drop_cnt=3`, `level=6`, `peak_level=6`.
  - The head entry is still the first event written.
- Full FIFO with push and pop together (`DROP_ON_FULL=1`): `level` goes 6→5 and `drop_cnt` +1.
- Assert `rst` at `level=40` mid-stream: the next cycle shows `level=0` and `empty=1`, and the first subsequent push appears with 1-cycle latency.
